// File: rtl/mem_bus_ctrl_if.sv
// Cache-side and RAM-side signal bundle for mem_bus_ctrl.
// master: the controller (drives waits, loads and RAM strobes).
// slave : the environment (caches and RAM model).
interface mem_bus_ctrl_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
);
  logic [CPUS-1:0]        iREN, dREN, dWEN;
  logic [CPUS*ADDR_W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]        iwait, dwait;
  logic [ADDR_W-1:0]      iload, dload;
  logic                   ramREN, ramWEN;
  logic [ADDR_W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]             ramstate;

  modport master (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: arbitrates per-CPU icache/dcache requests onto one
// single-ported RAM, one transaction in flight.
// Optional macro MEMBUS_RR_ARB_EN: round-robin across CPUs instead of
// fixed lowest-index priority.
module mem_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input  logic            CLK,
  input  logic            RST,
  mem_bus_ctrl_if.master  bus
);
  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, RETRY} state_t;
  typedef enum logic [1:0] {CLS_I, CLS_DR, CLS_DW} cls_t;

  state_t            state_q;
  cls_t              cls_q;
  logic [IDX_W-1:0]  gnt_q;
  logic [ADDR_W-1:0] addr_q, store_q;
  logic              ren_q, wen_q;
  logic [ADDR_W-1:0] iload_q, dload_q;
`ifdef MEMBUS_RR_ARB_EN
  logic [IDX_W-1:0]  ptr_q;
`endif

  logic [CPUS-1:0]   pend;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  cls_t              win_cls;
  logic [ADDR_W-1:0] win_addr, win_store;
  logic              done;
  int                idx;

  assign pend = bus.iREN | bus.dREN | bus.dWEN;
  assign done = (state_q == REQ) && (bus.ramstate == RS_ACCESS);

  // Pick the winning CPU and its highest-priority request class.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_cls   = CLS_I;
    win_addr  = '0;
    win_store = '0;
    idx       = 0;
    for (int k = 0; k < CPUS; k++) begin
`ifdef MEMBUS_RR_ARB_EN
      idx = (int'(ptr_q) + k) % CPUS;
`else
      idx = k;
`endif
      if (!win_found && pend[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
        win_store = bus.dstore[idx*ADDR_W +: ADDR_W];
        if (bus.dWEN[idx]) begin
          win_cls  = CLS_DW;
          win_addr = bus.daddr[idx*ADDR_W +: ADDR_W];
        end else if (bus.dREN[idx]) begin
          win_cls  = CLS_DR;
          win_addr = bus.daddr[idx*ADDR_W +: ADDR_W];
        end else begin
          win_cls  = CLS_I;
          win_addr = bus.iaddr[idx*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Wait and load are combinational on the ACCESS cycle so completion is
  // visible in the same cycle RAM answers; loads hold their last value.
  always_comb begin
    bus.iwait = '1;
    bus.dwait = '1;
    bus.iload = iload_q;
    bus.dload = dload_q;
    if (done) begin
      if (cls_q == CLS_I) begin
        bus.iwait[gnt_q] = 1'b0;
        bus.iload        = bus.ramload;
      end else begin
        bus.dwait[gnt_q] = 1'b0;
        if (cls_q == CLS_DR) bus.dload = bus.ramload;
      end
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;

  // Transaction FSM with registered RAM strobes, address and data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cls_q   <= CLS_I;
      gnt_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
`ifdef MEMBUS_RR_ARB_EN
      ptr_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (win_found) begin
          state_q <= REQ;
          gnt_q   <= win_idx;
          cls_q   <= win_cls;
          addr_q  <= win_addr;
          store_q <= win_store;
          ren_q   <= (win_cls != CLS_DW);
          wen_q   <= (win_cls == CLS_DW);
        end
        REQ: begin
          if (bus.ramstate == RS_ACCESS) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            if (cls_q == CLS_I)  iload_q <= bus.ramload;
            if (cls_q == CLS_DR) dload_q <= bus.ramload;
`ifdef MEMBUS_RR_ARB_EN
            ptr_q <= (int'(gnt_q) + 1 >= CPUS) ? '0 : IDX_W'(int'(gnt_q) + 1);
`endif
          end else if (bus.ramstate == RS_ERROR) begin
            state_q <= RETRY;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
          end
        end
        RETRY: begin
          // Reissue the latched request unchanged.
          state_q <= REQ;
          ren_q   <= (cls_q != CLS_DW);
          wen_q   <= (cls_q == CLS_DW);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (CPUS=2, ADDR_W=32).
module tb_mem_bus_ctrl;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  mem_bus_ctrl_if #(.CPUS(2), .ADDR_W(32)) b ();
  mem_bus_ctrl #(.CPUS(2), .ADDR_W(32)) dut (.CLK(CLK), .RST(RST), .bus(b));

  always #5 CLK = ~CLK;

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    b.iREN = '0; b.dREN = '0; b.dWEN = '0;
    b.iaddr = '0; b.daddr = '0; b.dstore = '0;
    b.ramload = '0; b.ramstate = FREE;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    tick(); tick();
    RST = 1'b0;
    #1;
    checks++; if (b.iwait !== 2'b11) begin errors++; $display("FAIL reset_iwait got=%b exp=11", b.iwait); end
    checks++; if (b.dwait !== 2'b11) begin errors++; $display("FAIL reset_dwait got=%b exp=11", b.dwait); end
    checks++; if ({b.ramREN, b.ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {b.ramREN, b.ramWEN}); end
    checks++; if (b.ramaddr !== 32'h0 || b.ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramaddr got=%h/%h exp=0/0", b.ramaddr, b.ramstore); end
    checks++; if (b.iload !== 32'h0 || b.dload !== 32'h0) begin errors++; $display("FAIL reset_loads got=%h/%h exp=0/0", b.iload, b.dload); end
    tick(); tick(); #1;
    checks++; if ({b.ramREN, b.ramWEN} !== 2'b00 || b.iwait !== 2'b11) begin errors++; $display("FAIL idle_stays got=%b/%b exp=00/11", {b.ramREN, b.ramWEN}, b.iwait); end
  endtask

  task automatic test_ifetch();
    b.iREN[0] = 1'b1; b.iaddr[31:0] = 32'h40;
    #1;
    checks++; if (b.ramREN !== 1'b0 || b.iwait !== 2'b11) begin errors++; $display("FAIL if_idle got=%b/%b exp=0/11", b.ramREN, b.iwait); end
    tick();
    b.ramstate = ACCESS; b.ramload = 32'h8C010004;
    #1;
    checks++; if (b.ramREN !== 1'b1 || b.ramWEN !== 1'b0) begin errors++; $display("FAIL if_strobe got=%b%b exp=10", b.ramREN, b.ramWEN); end
    checks++; if (b.ramaddr !== 32'h40) begin errors++; $display("FAIL if_addr got=%h exp=00000040", b.ramaddr); end
    checks++; if (b.iwait !== 2'b10 || b.dwait !== 2'b11) begin errors++; $display("FAIL if_wait got=%b/%b exp=10/11", b.iwait, b.dwait); end
    checks++; if (b.iload !== 32'h8C010004) begin errors++; $display("FAIL if_load got=%h exp=8c010004", b.iload); end
    tick();
    b.iREN = '0; b.ramstate = FREE; b.ramload = 32'h0;
    #1;
    checks++; if (b.ramREN !== 1'b0 || b.iwait !== 2'b11) begin errors++; $display("FAIL if_after got=%b/%b exp=0/11", b.ramREN, b.iwait); end
    checks++; if (b.iload !== 32'h8C010004) begin errors++; $display("FAIL if_hold got=%h exp=8c010004", b.iload); end
  endtask

  task automatic test_write();
    int hi = 0;
    b.dWEN[0] = 1'b1; b.daddr[31:0] = 32'h100; b.dstore[31:0] = 32'hDEADBEEF;
    tick();
    for (int c = 0; c < 4; c++) begin
      b.ramstate = (c == 3) ? ACCESS : BUSY;
      #1;
      if (b.ramWEN === 1'b1) hi++;
      checks++; if (b.dwait !== ((c == 3) ? 2'b10 : 2'b11)) begin errors++; $display("FAIL wr_dwait c=%0d got=%b exp=%b", c, b.dwait, (c == 3) ? 2'b10 : 2'b11); end
      if (c == 0) begin
        checks++; if (b.ramaddr !== 32'h100 || b.ramstore !== 32'hDEADBEEF || b.ramREN !== 1'b0) begin errors++; $display("FAIL wr_bus got=%h/%h/%b exp=00000100/deadbeef/0", b.ramaddr, b.ramstore, b.ramREN); end
      end
      tick();
    end
    b.dWEN = '0; b.ramstate = FREE;
    #1;
    checks++; if (hi != 4) begin errors++; $display("FAIL wr_len got=%0d exp=4", hi); end
    checks++; if (b.ramWEN !== 1'b0 || b.dwait !== 2'b11) begin errors++; $display("FAIL wr_after got=%b/%b exp=0/11", b.ramWEN, b.dwait); end
  endtask

  task automatic test_class_prio();
    b.iREN[0] = 1'b1; b.dREN[0] = 1'b1; b.iaddr[31:0] = 32'h10; b.daddr[31:0] = 32'h20;
    tick();
    b.ramstate = ACCESS; b.ramload = 32'h1111;
    #1;
    checks++; if (b.ramaddr !== 32'h20 || b.ramREN !== 1'b1) begin errors++; $display("FAIL cp_first got=%h/%b exp=00000020/1", b.ramaddr, b.ramREN); end
    checks++; if (b.dwait !== 2'b10 || b.iwait !== 2'b11 || b.dload !== 32'h1111) begin errors++; $display("FAIL cp_dresp got=%b/%b/%h exp=10/11/00001111", b.dwait, b.iwait, b.dload); end
    tick();
    b.dREN = '0; b.ramstate = FREE;
    #1;
    checks++; if (b.ramREN !== 1'b0) begin errors++; $display("FAIL cp_gap got=%b exp=0", b.ramREN); end
    tick();
    b.ramstate = ACCESS; b.ramload = 32'h2222;
    #1;
    checks++; if (b.ramaddr !== 32'h10 || b.iwait !== 2'b10 || b.iload !== 32'h2222) begin errors++; $display("FAIL cp_second got=%h/%b/%h exp=00000010/10/00002222", b.ramaddr, b.iwait, b.iload); end
    checks++; if (b.dload !== 32'h1111) begin errors++; $display("FAIL cp_dhold got=%h exp=00001111", b.dload); end
    tick();
    b.iREN = '0; b.ramstate = FREE;
  endtask

  task automatic test_arbitration();
    logic exp_cpu;
    RST = 1'b1; clear_inputs();
    tick();
    RST = 1'b0;
    b.iREN = 2'b11; b.iaddr = {32'h400, 32'h300};
    for (int t = 0; t < 4; t++) begin
`ifdef MEMBUS_RR_ARB_EN
      exp_cpu = t[0];
`else
      exp_cpu = 1'b0;
`endif
      tick();
      b.ramstate = ACCESS;
      #1;
      checks++; if (b.iwait !== (exp_cpu ? 2'b01 : 2'b10) || b.ramaddr !== (exp_cpu ? 32'h400 : 32'h300)) begin
        errors++; $display("FAIL arb t=%0d got=%b/%h exp_cpu=%0d", t, b.iwait, b.ramaddr, exp_cpu);
      end
      tick();
      b.ramstate = FREE;
    end
    b.iREN = '0;
  endtask

  task automatic test_error_retry();
    b.dREN[0] = 1'b1; b.daddr[31:0] = 32'h200;
    tick();
    b.ramstate = ERROR;
    #1;
    checks++; if (b.ramREN !== 1'b1 || b.dwait !== 2'b11) begin errors++; $display("FAIL er_req got=%b/%b exp=1/11", b.ramREN, b.dwait); end
    tick();
    b.ramstate = FREE;
    #1;
    checks++; if (b.ramREN !== 1'b0 || b.dwait !== 2'b11) begin errors++; $display("FAIL er_retry got=%b/%b exp=0/11", b.ramREN, b.dwait); end
    tick();
    b.ramstate = ACCESS; b.ramload = 32'hCAFEF00D;
    #1;
    checks++; if (b.ramREN !== 1'b1 || b.ramaddr !== 32'h200) begin errors++; $display("FAIL er_reissue got=%b/%h exp=1/00000200", b.ramREN, b.ramaddr); end
    checks++; if (b.dwait !== 2'b10 || b.dload !== 32'hCAFEF00D) begin errors++; $display("FAIL er_done got=%b/%h exp=10/cafef00d", b.dwait, b.dload); end
    tick();
    b.dREN = '0; b.ramstate = FREE;
  endtask

  task automatic test_reset_mid();
    b.dWEN[1] = 1'b1; b.daddr[63:32] = 32'h500; b.dstore[63:32] = 32'h12345678;
    tick();
    b.ramstate = BUSY;
    #1;
    checks++; if (b.ramWEN !== 1'b1 || b.ramaddr !== 32'h500) begin errors++; $display("FAIL rm_req got=%b/%h exp=1/00000500", b.ramWEN, b.ramaddr); end
    RST = 1'b1;
    tick();
    b.dWEN = '0;
    #1;
    checks++; if (b.ramWEN !== 1'b0 || b.ramaddr !== 32'h0 || b.dwait !== 2'b11 || b.dload !== 32'h0) begin
      errors++; $display("FAIL rm_abort got=%b/%h/%b/%h exp=0/0/11/0", b.ramWEN, b.ramaddr, b.dwait, b.dload);
    end
    RST = 1'b0;
    b.ramstate = FREE;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_ifetch();
    test_write();
    test_class_prio();
    test_error_retry();
    test_arbitration();
    test_reset_mid();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side responder for the cache request interface; serves icache/dcache miss and writeback traffic from CPUS cache pairs.
- Arbitrates every iREN/dREN/dWEN request onto one single-ported RAM port and returns data plus per-requester wait handshakes.
- Sits between the per-core caches blocks and the RAM model, one transaction in flight at a time.

Parameters:
- CPUS, 2, number of cache pairs served (1..4)
- ADDR_W, 32, address/data word width

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- iREN  in  CPUS  instruction read request per CPU
- dREN  in  CPUS  data read request per CPU
- dWEN  in  CPUS  data write request per CPU
- iaddr  in  CPUS*ADDR_W  instruction address, CPU n at [n*ADDR_W +: ADDR_W]
- daddr  in  CPUS*ADDR_W  data address, same packing
- dstore  in  CPUS*ADDR_W  write data, same packing
- iwait  out  CPUS  1 = instruction request not complete
- dwait  out  CPUS  1 = data request not complete
- iload  out  ADDR_W  instruction read data, valid when the granted iwait bit is 0
- dload  out  ADDR_W  data read data, valid when the granted dwait bit is 0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Clock CLK only; reset RST is synchronous and active-high. All state updates on rising CLK.
- Reset values: state IDLE; ramREN = 0, ramWEN = 0; ramaddr and ramstore = 0; iwait and dwait all 1s; iload and dload = 0; grant registers cleared; RR pointer = 0.
- Per-CPU request class priority: dWEN > dREN > iREN. If dWEN and dREN are both set for one CPU, the request is a write.
- Across CPUs, the lowest index with any pending request wins (fixed priority).
- States:
  - IDLE: if any request is pending, register the winning CPU, class, address and store data, then go to REQ. Otherwise stay in IDLE.
  - REQ: drive ramREN or ramWEN with the registered address and data. Hold until ramstate == ACCESS.
  - On ACCESS in REQ, in the same cycle: clear the granted requester's wait bit, drive iload/dload = ramload for reads, then go to IDLE. Wait is low for exactly one cycle.
  - ramstate ERROR in REQ: drop the strobes for one cycle (state RETRY), then return to REQ and reissue the same request. Wait stays high throughout.
- Other outputs:
  - All non-granted wait bits stay 1 at all times.
  - iload and dload hold their last value when not being updated.
  - Strobes are 0 in IDLE and RETRY.
- Minimum latency from request to wait-low is 2 cycles (IDLE, then REQ with ACCESS).
- Request withdrawn while in REQ: the transaction still completes. Requesters must hold a request until they see their wait bit low.
- Request held after completion: it is re-arbitrated in the next IDLE. No back-to-back issue without the IDLE cycle.
- RST asserted mid-transaction: abort immediately, with reset values on the next edge. No RAM write completion is guaranteed.

Optional Feature:
- Macro MEMBUS_RR_ARB_EN.
- Defined: cross-CPU arbitration is round-robin. Search starts at the RR pointer. After each completed transaction the pointer becomes (granted CPU + 1) mod CPUS. Class priority within a CPU is unchanged.
- Undefined: fixed lowest-index priority, and no pointer register is instantiated.

Test Plan:
- Reset held 2 cycles, then released with no requests -> iwait = dwait = all 1s, ramREN = ramWEN = 0, stays in IDLE.
- CPU0 iREN, iaddr = 0x40; RAM returns ACCESS on the 1st REQ cycle with ramload = 0x8C010004 -> ramREN high 1 cycle, ramaddr = 0x40, iwait[0] low that cycle, iload = 0x8C010004.
- CPU0 dWEN, daddr = 0x100, dstore = 0xDEADBEEF; RAM BUSY 3 cycles then ACCESS -> ramWEN high 4 cycles, dwait[0] low only in the 4th.
- CPU0 iREN and dREN both set, same cycle -> data read served first, then instruction read after an IDLE cycle.
- CPU0 and CPU1 both requesting continuously, 4 transactions -> without the macro all 4 go to CPU0; with MEMBUS_RR_ARB_EN they alternate 0, 1, 0, 1.
- RAM returns ERROR once during a read of 0x200 -> strobe drops 1 cycle, request is reissued at 0x200, completes on ACCESS, dwait stays high until then.
